draw_control_fsm: RTL and testbench

//  Control FSM directly upstream of the drawing datapath in the VGA car game.

---
 rtl/draw_control_fsm_if.sv | 35 +++
 rtl/draw_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_draw_control_fsm.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_control_fsm_if.sv
// Bundle between the draw control FSM and its neighbours: the game-level
// requests (start, frame tick, steering) and the datapath controls
// (one-hot draw enables, plot/inc strobes, done pulses, car position).
// master: the control FSM. slave: the datapath / environment side.
interface draw_control_fsm_if;
  logic       start;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;

  logic       draw_bg_green_left;
  logic       draw_bg_black;
  logic       draw_bg_green_right;
  logic       draw_car;
  logic       erase;
  logic       plot;
  logic       inc;
  logic       done_bg;
  logic       done_car;
  logic       done_erase;
  logic       done_update;
  logic [7:0] car_x;

  modport master (
    input  start, frame_tick, move_left, move_right,
    output draw_bg_green_left, draw_bg_black, draw_bg_green_right, draw_car, erase,
    output plot, inc, done_bg, done_car, done_erase, done_update, car_x
  );

  modport slave (
    output start, frame_tick, move_left, move_right,
    input  draw_bg_green_left, draw_bg_black, draw_bg_green_right, draw_car, erase,
    input  plot, inc, done_bg, done_car, done_erase, done_update, car_x
  );
endinterface

// File: rtl/draw_control_fsm.sv
// Control FSM for the VGA car game drawing datapath.
// Sequences background strips, the car, and the per-frame erase/move/redraw
// loop; times every region with shadow x/y counters and owns car_x.
// Optional build macro CAR_WRAP_EN: when defined the car wraps around the
// road edges instead of saturating at them.
module draw_control_fsm #(
  parameter int LEFT_W  = 30,
  parameter int ROAD_W  = 100,
  parameter int RIGHT_W = 30,
  parameter int SCR_H   = 120,
  parameter int CAR_W   = 8,
  parameter int CAR_H   = 12,
  parameter int STEP    = 2,
  parameter int CAR_X0  = 80
) (
  input  logic                clock,
  input  logic                reset,
  draw_control_fsm_if.master  bus
);

  // Legal car left-edge range: the car must stay fully on the road.
  localparam logic [7:0] X_MIN = 8'(LEFT_W);
  localparam logic [7:0] X_MAX = 8'(LEFT_W + ROAD_W - CAR_W);

`ifdef CAR_WRAP_EN
  // Stepping off one edge re-enters at the opposite edge.
  localparam logic [7:0] LEFT_LIMIT_X  = X_MAX;
  localparam logic [7:0] RIGHT_LIMIT_X = X_MIN;
`else
  // Stepping off an edge pins the car to that edge.
  localparam logic [7:0] LEFT_LIMIT_X  = X_MIN;
  localparam logic [7:0] RIGHT_LIMIT_X = X_MAX;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_BG_LEFT,
    S_BG_BLACK,
    S_BG_RIGHT,
    S_CAR,
    S_WAIT,
    S_ERASE,
    S_UPDATE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [7:0] cy_q, cy_d;
  logic [7:0] car_x_q, car_x_d;
  logic       pending_q, pending_d;

  logic       drawing;
  logic [7:0] w_last;
  logic [7:0] h_last;
  logic       row_end;
  logic       last_px;
  logic [7:0] left_x;
  logic [7:0] right_x;

  // Region geometry of the current drawing state (last column / last row).
  always_comb begin
    drawing = 1'b0;
    w_last  = 8'(CAR_W - 1);
    h_last  = 8'(CAR_H - 1);
    case (state_q)
      S_BG_LEFT: begin
        drawing = 1'b1;
        w_last  = 8'(LEFT_W - 1);
        h_last  = 8'(SCR_H - 1);
      end
      S_BG_BLACK: begin
        drawing = 1'b1;
        w_last  = 8'(ROAD_W - 1);
        h_last  = 8'(SCR_H - 1);
      end
      S_BG_RIGHT: begin
        drawing = 1'b1;
        w_last  = 8'(RIGHT_W - 1);
        h_last  = 8'(SCR_H - 1);
      end
      S_CAR, S_ERASE: begin
        drawing = 1'b1;
      end
      default: begin
        drawing = 1'b0;
      end
    endcase
  end

  assign row_end = drawing && (cx_q == w_last);
  assign last_px = row_end && (cy_q == h_last);

  // Candidate car positions for a single left or right step, edge-limited.
  always_comb begin
    if ({1'b0, car_x_q} < 9'(LEFT_W + STEP)) begin
      left_x = LEFT_LIMIT_X;
    end else begin
      left_x = car_x_q - 8'(STEP);
    end
    if (({1'b0, car_x_q} + 9'(STEP)) > {1'b0, X_MAX}) begin
      right_x = RIGHT_LIMIT_X;
    end else begin
      right_x = car_x_q + 8'(STEP);
    end
  end

  // State register: FSM state, shadow counters, frame-pending flag, car position.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cx_q      <= 8'd0;
      cy_q      <= 8'd0;
      car_x_q   <= 8'(CAR_X0);
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      car_x_q   <= car_x_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic: phase sequencing, raster counters, pending flag, car move.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    car_x_d   = car_x_q;
    pending_d = pending_q;

    if (drawing) begin
      if (row_end) begin
        cx_d = 8'd0;
        cy_d = last_px ? 8'd0 : cy_q + 8'd1;
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE:     if (bus.start) state_d = S_BG_LEFT;
      S_BG_LEFT:  if (last_px)   state_d = S_BG_BLACK;
      S_BG_BLACK: if (last_px)   state_d = S_BG_RIGHT;
      S_BG_RIGHT: if (last_px)   state_d = S_CAR;
      S_CAR:      if (last_px)   state_d = S_WAIT;
      S_WAIT:     if (pending_q) state_d = S_ERASE;
      S_ERASE:    if (last_px)   state_d = S_UPDATE;
      S_UPDATE: begin
        state_d = S_CAR;
        if (bus.move_left && !bus.move_right) begin
          car_x_d = left_x;
        end else if (bus.move_right && !bus.move_left) begin
          car_x_d = right_x;
        end
      end
      default:    state_d = S_IDLE;
    endcase

    // Consuming the pending frame wins over a tick in the same cycle.
    if ((state_q == S_WAIT) && pending_q) begin
      pending_d = 1'b0;
    end else if ((state_q != S_IDLE) && bus.frame_tick) begin
      pending_d = 1'b1;
    end
  end

  // Moore output decode from the registered state and counters.
  always_comb begin
    bus.draw_bg_green_left  = (state_q == S_BG_LEFT);
    bus.draw_bg_black       = (state_q == S_BG_BLACK);
    bus.draw_bg_green_right = (state_q == S_BG_RIGHT);
    bus.draw_car            = (state_q == S_CAR);
    bus.erase               = (state_q == S_ERASE);
    bus.plot                = drawing;
    bus.inc                 = row_end;
    bus.done_bg             = last_px && ((state_q == S_BG_LEFT) ||
                                          (state_q == S_BG_BLACK) ||
                                          (state_q == S_BG_RIGHT));
    bus.done_car            = last_px && (state_q == S_CAR);
    bus.done_erase          = last_px && (state_q == S_ERASE);
    bus.done_update         = (state_q == S_UPDATE);
    bus.car_x               = car_x_q;
  end

endmodule

// File: tb/tb_draw_control_fsm.sv
// Scoreboard bench for draw_control_fsm. Stimulus pushes expected drawing
// phases (kind, pixel count, row count, car_x) computed from the region
// sizes and movement rules; a monitor rebuilds phases from the outputs and
// pops/compares one entry per completed phase.
`timescale 1ns/1ps
module tb_draw_control_fsm;

  localparam int LEFT_W  = 30;
  localparam int ROAD_W  = 100;
  localparam int RIGHT_W = 30;
  localparam int SCR_H   = 120;
  localparam int CAR_W   = 8;
  localparam int CAR_H   = 12;
  localparam int STEP    = 2;
  localparam int CAR_X0  = 80;
  localparam int XMIN    = LEFT_W;
  localparam int XMAX    = LEFT_W + ROAD_W - CAR_W;
  localparam int FRAME_CYC = 195;  // tick -> back in WAIT for one erase/update/car loop

  localparam int K_LEFT = 0, K_BLACK = 1, K_RIGHT = 2, K_CAR = 3, K_ERASE = 4, K_UPD = 5;

  typedef struct {
    int kind;
    int cycles;
    int incs;
    int x;
    int bad;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   stray = 0;
  int   mx;
  rec_t exp_q[$];

  draw_control_fsm_if dif();

  draw_control_fsm #(
    .LEFT_W(LEFT_W), .ROAD_W(ROAD_W), .RIGHT_W(RIGHT_W), .SCR_H(SCR_H),
    .CAR_W(CAR_W), .CAR_H(CAR_H), .STEP(STEP), .CAR_X0(CAR_X0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dif.master)
  );

  always #5 clock = ~clock;

  function automatic int reg_w(input int k);
    case (k)
      K_LEFT:  return LEFT_W;
      K_BLACK: return ROAD_W;
      K_RIGHT: return RIGHT_W;
      default: return CAR_W;
    endcase
  endfunction

  function automatic int reg_h(input int k);
    return (k <= K_RIGHT) ? SCR_H : CAR_H;
  endfunction

  function automatic int moved(input int x, input bit l, input bit r);
    int n;
    if (l == r) return x;
    n = l ? x - STEP : x + STEP;
`ifdef CAR_WRAP_EN
    if (n < XMIN) return XMAX;
    if (n > XMAX) return XMIN;
`else
    if (n < XMIN) return XMIN;
    if (n > XMAX) return XMAX;
`endif
    return n;
  endfunction

  function automatic int rnd_extra();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 3));
    return 0;
  endfunction

  task automatic push(input int k, input int x);
    rec_t e;
    e.kind = k;
    e.x    = x;
    e.bad  = 0;
    if (k == K_UPD) begin
      e.cycles = 1;
      e.incs   = 0;
    end else begin
      e.cycles = reg_w(k) * reg_h(k);
      e.incs   = reg_h(k);
    end
    exp_q.push_back(e);
  endtask

  task automatic push_draw(input int x);
    push(K_LEFT, x);
    push(K_BLACK, x);
    push(K_RIGHT, x);
    push(K_CAR, x);
  endtask

  task automatic push_frame(input bit l, input bit r);
    int nx;
    nx = moved(mx, l, r);
    push(K_ERASE, mx);
    push(K_UPD, nx);
    push(K_CAR, nx);
    mx = nx;
  endtask

  task automatic check_rec(input rec_t a);
    rec_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL phase_unexpected: actual kind=%0d cycles=%0d incs=%0d car_x=%0d, required no phase",
               a.kind, a.cycles, a.incs, a.x);
    end else begin
      e = exp_q.pop_front();
      if (a.kind != e.kind || a.cycles != e.cycles || a.incs != e.incs ||
          a.x != e.x || a.bad != 0) begin
        n_err++;
        $display("FAIL phase_k%0d: actual kind=%0d cycles=%0d incs=%0d car_x=%0d bad=%0d, required kind=%0d cycles=%0d incs=%0d car_x=%0d bad=0",
                 e.kind, a.kind, a.cycles, a.incs, a.x, a.bad, e.kind, e.cycles, e.incs, e.x);
      end else begin
        $display("ok   phase kind=%0d cycles=%0d incs=%0d car_x=%0d", a.kind, a.cycles, a.incs, a.x);
      end
    end
  endtask

  task automatic check_idle(input string tag, input int xexp);
    logic [10:0] v;
    @(negedge clock);
    v = {dif.draw_bg_green_left, dif.draw_bg_black, dif.draw_bg_green_right, dif.draw_car,
         dif.erase, dif.plot, dif.inc, dif.done_bg, dif.done_car, dif.done_erase, dif.done_update};
    n_cmp++;
    if (v != 11'd0 || dif.car_x != 8'(xexp)) begin
      n_err++;
      $display("FAIL %s: actual outputs=%b car_x=%0d, required outputs=0 car_x=%0d",
               tag, v, dif.car_x, xexp);
    end else begin
      $display("ok   %s outputs=0 car_x=%0d", tag, dif.car_x);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    dif.start = 1'b1;
    step(1);
    dif.start = 1'b0;
  endtask

  task automatic pulse_tick();
    dif.frame_tick = 1'b1;
    step(1);
    dif.frame_tick = 1'b0;
  endtask

  // One frame request issued in WAIT, optionally followed by extra ticks
  // while the loop is busy (at most one more frame) or a tick exactly on
  // the WAIT->ERASE cycle (no extra frame).
  task automatic burst(input bit l, input bit r, input int extra, input bit same_cycle);
    int frames;
    int t;
    int d;
    dif.move_left  = l;
    dif.move_right = r;
    push_frame(l, r);
    frames = 1;
    pulse_tick();
    t = 1;
    if (same_cycle) begin
      pulse_tick();
      t++;
    end
    for (int i = 0; i < extra; i++) begin
      d = int'($urandom_range(20, 40));
      step(d);
      t += d;
      if (frames == 1) begin
        push_frame(l, r);
        frames = 2;
      end
      pulse_tick();
      t++;
    end
    step(frames * FRAME_CYC + 10 + int'($urandom_range(0, 20)) - t);
    dif.move_left  = 1'b0;
    dif.move_right = 1'b0;
  endtask

  // Monitor: rebuild phases from the outputs and compare each against the scoreboard.
  initial begin : monitor
    rec_t cur;
    bit   open;
    bit   upd_wait;
    logic [4:0] en;
    int   k;
    int   w;
    int   h;
    bit   last;
    rec_t u;
    open     = 1'b0;
    upd_wait = 1'b0;
    cur      = '{kind: 0, cycles: 0, incs: 0, x: 0, bad: 0};
    forever begin
      @(negedge clock);
      en = {dif.erase, dif.draw_car, dif.draw_bg_green_right, dif.draw_bg_black,
            dif.draw_bg_green_left};
      if (reset) begin
        open     = 1'b0;
        upd_wait = 1'b0;
      end else begin
        if (upd_wait) begin
          u = '{kind: K_UPD, cycles: 1, incs: 0, x: int'(dif.car_x), bad: 0};
          check_rec(u);
          upd_wait = 1'b0;
        end
        if (en == 5'd0) begin
          if (open) begin
            cur.bad = 1;
            check_rec(cur);
            open = 1'b0;
          end
          if (dif.plot || dif.inc || dif.done_bg || dif.done_car || dif.done_erase) stray++;
          if (dif.done_update) upd_wait = 1'b1;
        end else begin
          k = 0;
          for (int i = 0; i < 5; i++) if (en[i]) k = i;
          if (open && cur.kind != k) begin
            cur.bad = 1;
            check_rec(cur);
            open = 1'b0;
          end
          if (!open) begin
            cur  = '{kind: k, cycles: 0, incs: 0, x: int'(dif.car_x), bad: 0};
            open = 1'b1;
          end
          w = reg_w(k);
          h = reg_h(k);
          last = (cur.cycles == w * h - 1);
          if ($countones(en) != 1) cur.bad = 1;
          if (int'(dif.car_x) != cur.x) cur.bad = 1;
          if (!dif.plot || dif.done_update) cur.bad = 1;
          if (dif.inc != ((cur.cycles % w) == w - 1)) cur.bad = 1;
          if (dif.done_bg    != (last && k <= K_RIGHT)) cur.bad = 1;
          if (dif.done_car   != (last && k == K_CAR))   cur.bad = 1;
          if (dif.done_erase != (last && k == K_ERASE)) cur.bad = 1;
          if (dif.inc) cur.incs++;
          cur.cycles++;
          if (last) begin
            check_rec(cur);
            open = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin : stimulus
    dif.start      = 1'b0;
    dif.frame_tick = 1'b0;
    dif.move_left  = 1'b0;
    dif.move_right = 1'b0;
    mx = CAR_X0;

    reset = 1'b1;
    step(3);
    reset = 1'b0;
    check_idle("reset_state", CAR_X0);

    // Full draw; three ticks during BG_BLACK give exactly one frame loop (right move).
    dif.move_right = 1'b1;
    push_draw(mx);
    push_frame(1'b0, 1'b1);
    pulse_start();
    step(4999);
    pulse_tick();
    step(1999);
    pulse_tick();
    step(1999);
    pulse_tick();
    step(10600);
    dif.move_right = 1'b0;

    // Both moves hold position; a tick on the WAIT->ERASE cycle is dropped.
    burst(1'b1, 1'b1, 0, 1'b0);
    burst(1'b0, 1'b0, 0, 1'b1);

    // Drive into the left edge, then across to the right edge, then random.
    for (int i = 0; i < 28; i++) burst(1'b1, 1'b0, rnd_extra(), 1'b0);
    for (int i = 0; i < 48; i++) burst(1'b0, 1'b1, rnd_extra(), 1'b0);
    for (int i = 0; i < 6; i++) begin
      burst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_extra(), 1'b0);
    end

    // start outside IDLE must be ignored.
    pulse_start();
    step(300);

    // Reset restores the car position.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    mx = CAR_X0;
    check_idle("reset_after_moves", CAR_X0);

    // Reset in the middle of BG_BLACK (around row 50).
    push(K_LEFT, mx);
    pulse_start();
    step(8620);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_idle("reset_mid_draw", CAR_X0);

    // frame_tick in IDLE is ignored; a fresh start redraws from the top.
    pulse_tick();
    step(5);
    push_draw(mx);
    pulse_start();
    step(19400);
    check_idle("wait_after_redraw", CAR_X0);
    step(50);

    n_cmp++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL stray_strobes: actual %0d cycles with plot/inc/done outside a drawing phase, required 0", stray);
    end else begin
      $display("ok   stray_strobes 0");
    end

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL phases_outstanding: actual %0d expected phases never seen, required 0", exp_q.size());
    end else begin
      $display("ok   phases_outstanding 0");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
